raman_dual_accum_ratio: RTL
===========================

// Module: raman_dual_accum_ratio
// PURPOSE
//  Parametrised successor to the single-frame Raman accumulate/store/ratio chain.
//  - Takes the ADC sample stream, one sample per spectral point per sweep.
//  - Accumulates alternate sweeps into two banks: A (pump on), B (pump off).
//  - After the programmed number of sweep pairs, computes a fixed-point A/B ratio
//    per point with a sequential divider.
//  - Streams the ratios out over a valid/ready handshake, then re-arms for the next frame.
// PARAMETERS
//  DATA_W    12   ADC sample width (unsigned)
//  POINTS    10   samples (spectral points) per sweep, >=2
//  MEASURES  100  sweep pairs per frame, >=1
//  ACC_W     29   accumulator width; must be >= DATA_W+$clog2(MEASURES+1)
//  FRAC_W    8    fractional bits of the ratio
//  RATIO_W   12   output ratio width, saturating
// PORTS
//  clock       in   1        single clock, all logic rising-edge
//  reset_n     in   1        asynchronous active-low reset
//  enable      in   1        run; low aborts the frame and returns to IDLE next cycle
//  in_valid    in   1        in_data valid
//  in_ready    out  1        block accepts a sample (high only in ACCUM)
//  in_data     in   DATA_W   ADC sample
//  bank        out  1        bank of the current sweep: 0 = A, 1 = B (drives pump switch)
//  point_idx   out  clog2(POINTS)  point counter of the next sample
//  out_valid   out  1        ratio word valid
//  out_ready   in   1        downstream accepts the ratio word
//  out_point   out  clog2(POINTS)  point index of out_ratio
//  out_ratio   out  RATIO_W  saturated (A<<FRAC_W)/B
//  out_last    out  1        high with the word for point POINTS-1
//  busy        out  1        high in any state other than IDLE
//  frame_done  out  1        one-cycle pulse after the last ratio is accepted
// BEHAVIOUR
//  Reset values: all outputs 0; counters, accumulators and state cleared; state = IDLE.
//  States: IDLE -> ACCUM -> DIVIDE -> OUTPUT -> IDLE.
//  - IDLE: accumulators zero. enable=1 -> ACCUM on the next cycle with bank=0, point_idx=0.
//  - ACCUM: in_ready=1. A transfer is in_valid&in_ready.
//    - Each transfer adds in_data into acc[bank][point_idx]; point_idx increments.
//    - At point POINTS-1: point_idx wraps to 0 and bank toggles.
//    - A sweep counter increments when a B sweep completes.
//    - When the MEASURES-th B sweep completes -> DIVIDE, with in_ready low from the next cycle.
//  - DIVIDE: restoring divider, one quotient bit per cycle.
//    - ACC_W+FRAC_W cycles per point, points in order 0..POINTS-1.
//    - Each result is written to a POINTS-deep ratio buffer.
//    - After the last point -> OUTPUT.
//  - OUTPUT: presents buffer[k] with out_point=k.
//    - out_valid stays high, and data holds stable, until out_ready.
//    - k advances on each handshake.
//    - On the handshake with out_last: pulse frame_done, clear the accumulators, go to IDLE.
//    - From IDLE the next frame starts immediately if enable is still 1.
//  Arithmetic:
//  - Accumulators are unsigned ACC_W bits; the parameter constraint guarantees no overflow.
//  - Dividend = acc_A<<FRAC_W (ACC_W+FRAC_W bits); divisor = acc_B.
//  - Quotient > 2^RATIO_W-1 -> out_ratio = all ones.
//  - acc_B == 0 -> out_ratio = all ones (no divide performed, same cycle count).
//  Boundaries:
//  - in_valid low mid-sweep stalls the counters; no sample is lost or double-counted.
//  - enable low in any state: abort; accumulators and buffer cleared; out_valid drops;
//    frame_done is not pulsed.
//  - reset_n low at any time: immediate return to reset values, including mid-DIVIDE
//    and mid-OUTPUT.
//  - out_ready high before out_valid has no effect.
//  - Samples are refused (in_ready=0) in DIVIDE and OUTPUT.
//  Latency: the last B sample to first out_valid =
//    POINTS*(ACC_W+FRAC_W)+2 cycles.
// TESTING (POINTS=4, MEASURES=2, ACC_W=29, FRAC_W=8, RATIO_W=12 unless noted)
//  1. A sweeps all 100, B sweeps all 50, out_ready=1
//     -> ratios 0x200 for points 0..3, out_last on point 3, frame_done one cycle later.
//  2. B sweeps all 0 -> out_ratio=0xFFF all points.
//     A=4095, B=1 -> 0xFFF (saturation).
//  3. in_valid toggled randomly (50%) with ramp data
//     -> ratios match the reference model; bank toggles every 4 accepted samples.
//  4. out_ready low for 10 cycles at point 2
//     -> out_valid held, out_point=2 and out_ratio stable; resumes without loss.
//  5. enable dropped mid-ACCUM, then reasserted
//     -> next frame's ratios reflect only new samples (no residue), no frame_done.
//  6. reset_n pulsed mid-DIVIDE
//     -> all outputs 0 asynchronously; a clean frame after release gives correct ratios.
//     Latency check: last B sample to out_valid = 4*37+2 = 150 cycles.

Source files
------------

// File: rtl/raman_dual_accum_ratio.sv
// ============================================================================
// raman_dual_accum_ratio : pump-on/pump-off dual-bank accumulator with a
//                          per-point sequential A/B ratio divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

module raman_dual_accum_ratio #(
    parameter int DATA_W   = 12,
    parameter int POINTS   = 10,
    parameter int MEASURES = 100,
    parameter int ACC_W    = 29,
    parameter int FRAC_W   = 8,
    parameter int RATIO_W  = 12
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       bank,
    output logic [$clog2(POINTS)-1:0]  point_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(POINTS)-1:0]  out_point,
    output logic [RATIO_W-1:0]         out_ratio,
    output logic                       out_last,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int PTR_W = $clog2(POINTS);
    localparam int DIV_W = ACC_W + FRAC_W;
    localparam int BC_W  = $clog2(DIV_W);
    localparam int SW_W  = $clog2(MEASURES + 1);
    localparam logic [PTR_W-1:0] LAST_PT    = PTR_W'(POINTS - 1);
    localparam logic [BC_W-1:0]  LAST_BIT   = BC_W'(DIV_W - 1);
    localparam logic [SW_W-1:0]  LAST_SWEEP = SW_W'(MEASURES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t              state, state_next;
    logic                xfer, last_b, div_done, frame_end;
    logic [SW_W-1:0]     sweep_cnt;
    logic [ACC_W-1:0]    acc_a [POINTS];
    logic [ACC_W-1:0]    acc_b [POINTS];
    logic [RATIO_W-1:0]  ratio_buf [POINTS];

    logic                div_loaded, b_zero, q_bit;
    logic [PTR_W-1:0]    div_point, div_point_nxt, out_point_nxt;
    logic [BC_W-1:0]     bit_cnt;
    logic [DIV_W-1:0]    dvd, quo_full;
    logic [DIV_W-2:0]    quo;
    logic [ACC_W-1:0]    dvs, rem, rem_next;
    logic [ACC_W:0]      trial;
    logic [RATIO_W-1:0]  ratio_sat;

    assign xfer      = in_valid && in_ready;
    assign last_b    = xfer && bank && (point_idx == LAST_PT) && (sweep_cnt == LAST_SWEEP);
    assign div_done  = (state == DIVIDE) && div_loaded && (bit_cnt == LAST_BIT) && (div_point == LAST_PT);
    assign frame_end = (state == OUTPUT) && out_valid && out_ready && out_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable) state_next = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (!enable)     state_next = IDLE;
                else if (last_b) state_next = DIVIDE;
            end
            DIVIDE: begin
                if (!enable)       state_next = IDLE;
                else if (div_done) state_next = OUTPUT;
            end
            OUTPUT: begin
                if (!enable || frame_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank      <= 1'b0;
            point_idx <= '0;
            sweep_cnt <= '0;
        end else if (state_next != ACCUM) begin
            bank      <= 1'b0;
            point_idx <= '0;
            sweep_cnt <= '0;
        end else if (xfer) begin
            if (point_idx == LAST_PT) begin
                point_idx <= '0;
                bank      <= ~bank;
                if (bank) sweep_cnt <= sweep_cnt + 1'b1;
            end else begin
                point_idx <= point_idx + 1'b1;
            end
        end
    end

    // Every route back to IDLE (frame end or abort) passes through here, so banks start at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < POINTS; i++) begin
                acc_a[i] <= '0;
                acc_b[i] <= '0;
            end
        end else if (state_next == IDLE) begin
            for (int i = 0; i < POINTS; i++) begin
                acc_a[i] <= '0;
                acc_b[i] <= '0;
            end
        end else if (xfer) begin
            if (bank) acc_b[point_idx] <= acc_b[point_idx] + ACC_W'(in_data);
            else      acc_a[point_idx] <= acc_a[point_idx] + ACC_W'(in_data);
        end
    end

    // Restoring divider step; dividend bits stream out of dvd MSB first.
    always_comb begin
        trial         = {rem, dvd[DIV_W-1]};
        q_bit         = (trial >= {1'b0, dvs});
        rem_next      = q_bit ? ACC_W'(trial - {1'b0, dvs}) : trial[ACC_W-1:0];
        quo_full      = {quo, q_bit};
        ratio_sat     = (b_zero || (|quo_full[DIV_W-1:RATIO_W])) ? '1 : quo_full[RATIO_W-1:0];
        div_point_nxt = (div_point == LAST_PT) ? '0 : div_point + 1'b1;
        out_point_nxt = (out_point == LAST_PT) ? '0 : out_point + 1'b1;
    end

    // The first DIVIDE cycle only loads point 0; later operands load on each point's last bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_loaded <= 1'b0;
            div_point  <= '0;
            bit_cnt    <= '0;
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            quo        <= '0;
            b_zero     <= 1'b0;
        end else if (state != DIVIDE) begin
            div_loaded <= 1'b0;
            div_point  <= '0;
            bit_cnt    <= '0;
        end else if (!div_loaded || (bit_cnt == LAST_BIT)) begin
            div_loaded <= 1'b1;
            div_point  <= div_loaded ? div_point_nxt : '0;
            bit_cnt    <= '0;
            rem        <= '0;
            quo        <= '0;
            dvd        <= {acc_a[div_loaded ? div_point_nxt : '0], {FRAC_W{1'b0}}};
            dvs        <= acc_b[div_loaded ? div_point_nxt : '0];
            b_zero     <= (acc_b[div_loaded ? div_point_nxt : '0] == '0);
        end else begin
            bit_cnt    <= bit_cnt + 1'b1;
            rem        <= rem_next;
            quo        <= quo_full[DIV_W-2:0];
            dvd        <= {dvd[DIV_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < POINTS; i++) ratio_buf[i] <= '0;
        end else if (state_next == IDLE) begin
            for (int i = 0; i < POINTS; i++) ratio_buf[i] <= '0;
        end else if ((state == DIVIDE) && div_loaded && (bit_cnt == LAST_BIT)) begin
            ratio_buf[div_point] <= ratio_sat;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_point  <= '0;
            out_ratio  <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if ((state == OUTPUT) && (state_next == OUTPUT)) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_point <= '0;
                    out_ratio <= ratio_buf[0];
                    out_last  <= 1'b0;
                end else if (out_ready) begin
                    out_point <= out_point_nxt;
                    out_ratio <= ratio_buf[out_point_nxt];
                    out_last  <= (out_point_nxt == LAST_PT);
                end
            end else begin
                out_valid  <= 1'b0;
                out_point  <= '0;
                out_ratio  <= '0;
                out_last   <= 1'b0;
                frame_done <= enable && frame_end;
            end
        end
    end

endmodule

`default_nettype wire
